// File: rtl/mm_timer_pkg.sv
// -----------------------------------------------------------------------------
// mm_timer_pkg
// Shared definitions for the mm_timer_array peripheral: register offsets
// inside a channel window, CTRL bit positions, the prescaler select encoding
// and the divisor lookup used by every channel.
// -----------------------------------------------------------------------------
package mm_timer_pkg;

    // Register offsets within one channel's four-word window
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // CTRL bit positions
    localparam int CTRL_PSEL_LSB = 0;
    localparam int CTRL_PSEL_MSB = 1;
    localparam int CTRL_IE       = 2;
    localparam int CTRL_AUTO     = 3;
    localparam int CTRL_RUN      = 4;
    localparam int CTRL_W        = 5;

    // Prescaler is wide enough for the largest divisor (1024)
    localparam int PRESC_W = 10;

    typedef enum logic [1:0] {
        PSEL_DIV1    = 2'd0,
        PSEL_DIV8    = 2'd1,
        PSEL_DIV64   = 2'd2,
        PSEL_DIV1024 = 2'd3
    } psel_e;

    // Terminal prescaler value (divisor - 1) for a given select
    function automatic logic [PRESC_W-1:0] psel_div(input psel_e psel);
        logic [PRESC_W-1:0] div_m1;
        case (psel)
            PSEL_DIV1:    div_m1 = 10'd0;
            PSEL_DIV8:    div_m1 = 10'd7;
            PSEL_DIV64:   div_m1 = 10'd63;
            PSEL_DIV1024: div_m1 = 10'd1023;
            default:      div_m1 = 10'd0;
        endcase
        return div_m1;
    endfunction

endpackage

// File: rtl/mm_timer_ch.sv
// -----------------------------------------------------------------------------
// mm_timer_ch
// One timer channel: CTRL, LOAD, live count, 10-bit prescaler, FAST and FLAG
// state plus the tick / underflow logic.
//
// Ports
//   CLK        system clock, rising edge
//   RES_N      asynchronous active-low reset
//   ctrl_we    write CTRL this cycle (already qualified by chip select)
//   count_we   write COUNT this cycle (also sets LOAD, clears FAST/FLAG)
//   status_re  STATUS read this cycle (clears FLAG unless it is being set)
//   wr_data    write data
//   ctrl       current CTRL contents {RUN, AUTO, IE, PSEL[1:0]}
//   count      live count
//   fast       one-shot has expired and counts every clock
//   flag       underflow flag
// -----------------------------------------------------------------------------
module mm_timer_ch
    import mm_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RES_N,
    input  logic              ctrl_we,
    input  logic              count_we,
    input  logic              status_re,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  count,
    output logic              fast,
    output logic              flag
);

    logic [CTRL_W-1:0]  ctrl_r;
    logic [WIDTH-1:0]   load_r;
    logic [WIDTH-1:0]   count_r;
    logic [PRESC_W-1:0] presc_r;
    logic               fast_r;
    logic               flag_r;

    logic               run_s;
    logic               auto_s;
    logic [PRESC_W-1:0] div_m1_s;
    logic               tick_s;
    logic               underflow_s;

    logic [WIDTH-1:0]   count_nxt_s;
    logic [PRESC_W-1:0] presc_nxt_s;
    logic               fast_nxt_s;
    logic               flag_nxt_s;

    // Tick decode: FAST bypasses the prescaler entirely once a one-shot expires.
    // A PSEL change only alters the compare value, so it lands at the next match.
    always_comb begin
        run_s       = ctrl_r[CTRL_RUN];
        auto_s      = ctrl_r[CTRL_AUTO];
        div_m1_s    = psel_div(psel_e'(ctrl_r[CTRL_PSEL_MSB:CTRL_PSEL_LSB]));
        tick_s      = run_s && (fast_r || (presc_r == div_m1_s));
        underflow_s = tick_s && (count_r == {WIDTH{1'b0}});
    end

    // Next count: a COUNT write overrides any tick in the same cycle
    always_comb begin
        count_nxt_s = count_r;
        if (count_we) begin
            count_nxt_s = wr_data;
        end else if (underflow_s) begin
            if (auto_s) begin
                count_nxt_s = load_r;
            end else begin
                count_nxt_s = {WIDTH{1'b1}};
            end
        end else if (tick_s) begin
            count_nxt_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Next prescaler: restarts on COUNT write and on every tick, holds while stopped
    always_comb begin
        presc_nxt_s = presc_r;
        if (count_we) begin
            presc_nxt_s = {PRESC_W{1'b0}};
        end else if (tick_s) begin
            presc_nxt_s = {PRESC_W{1'b0}};
        end else if (run_s) begin
            presc_nxt_s = presc_r + 10'd1;
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Next FAST/FLAG: set by underflow beats the read-clear, COUNT write beats both
    always_comb begin
        fast_nxt_s = fast_r;
        flag_nxt_s = flag_r;
        if (count_we) begin
            fast_nxt_s = 1'b0;
            flag_nxt_s = 1'b0;
        end else if (underflow_s) begin
            flag_nxt_s = 1'b1;
            if (auto_s) begin
                fast_nxt_s = fast_r;
            end else begin
                fast_nxt_s = 1'b1;
            end
        end else if (status_re) begin
            fast_nxt_s = fast_r;
            flag_nxt_s = 1'b0;
        end else begin
            fast_nxt_s = fast_r;
            flag_nxt_s = flag_r;
        end
    end

    // CTRL register
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (ctrl_we) begin
            ctrl_r <= wr_data[CTRL_W-1:0];
        end
    end

    // LOAD register (reload value for auto-reload mode)
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            load_r <= {WIDTH{1'b0}};
        end else if (count_we) begin
            load_r <= wr_data;
        end
    end

    // Count, prescaler and status state
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            count_r <= {WIDTH{1'b0}};
            presc_r <= {PRESC_W{1'b0}};
            fast_r  <= 1'b0;
            flag_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            presc_r <= presc_nxt_s;
            fast_r  <= fast_nxt_s;
            flag_r  <= flag_nxt_s;
        end
    end

    assign ctrl  = ctrl_r;
    assign count = count_r;
    assign fast  = fast_r;
    assign flag  = flag_r;

endmodule

// File: rtl/mm_timer_array.sv
// -----------------------------------------------------------------------------
// mm_timer_array
// NCH independent interval timers behind a small CPU register bus. Each
// channel occupies four registers: CTRL, COUNT, STATUS, reserved.
//
// Ports
//   CLK     system clock, rising edge
//   RES_N   asynchronous active-low reset
//   CS      chip select, qualifies WE and RE
//   WE      write strobe
//   RE      read strobe (read side effects only when CS & RE)
//   A       {channel, reg[1:0]}
//   D_IN    write data
//   D_OUT   read data, combinational from A; zero unless CS & RE
//   IRQ_N   active-low interrupt, any channel with FLAG & IE
// -----------------------------------------------------------------------------
module mm_timer_array
    import mm_timer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RES_N,
    input  logic                    CS,
    input  logic                    WE,
    input  logic                    RE,
    input  logic [$clog2(NCH)+1:0]  A,
    input  logic [WIDTH-1:0]        D_IN,
    output logic [WIDTH-1:0]        D_OUT,
    output logic                    IRQ_N
);

    localparam int AW   = $clog2(NCH) + 2;
    // Channel index is kept at least one bit wide so NCH=1 still elaborates
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CH_W-1:0]   ch_idx_s;
    logic [1:0]        reg_s;
    logic              wr_s;
    logic              rd_s;
    logic [NCH-1:0]    ch_sel_s;

    logic [CTRL_W-1:0] ctrl_a  [NCH];
    logic [WIDTH-1:0]  count_a [NCH];
    logic [NCH-1:0]    fast_v_s;
    logic [NCH-1:0]    flag_v_s;
    logic [NCH-1:0]    ie_v_s;

    logic [CTRL_W-1:0] sel_ctrl_s;
    logic [WIDTH-1:0]  sel_count_s;
    logic              sel_fast_s;
    logic              sel_flag_s;
    logic [WIDTH-1:0]  rd_data_s;

    assign reg_s = A[1:0];
    assign wr_s  = CS && WE;
    assign rd_s  = CS && RE;

    generate
        if (AW > 2) begin : g_ch_idx
            assign ch_idx_s = A[AW-1:2];
        end else begin : g_ch_one
            assign ch_idx_s = 1'b0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            // Addresses beyond NCH-1 match no channel: reads 0, writes dropped
            assign ch_sel_s[gi] = (ch_idx_s == CH_W'(gi));

            mm_timer_ch #(
                .WIDTH (WIDTH)
            ) u_ch (
                .CLK       (CLK),
                .RES_N     (RES_N),
                .ctrl_we   (wr_s && ch_sel_s[gi] && (reg_s == REG_CTRL)),
                .count_we  (wr_s && ch_sel_s[gi] && (reg_s == REG_COUNT)),
                .status_re (rd_s && ch_sel_s[gi] && (reg_s == REG_STATUS)),
                .wr_data   (D_IN),
                .ctrl      (ctrl_a[gi]),
                .count     (count_a[gi]),
                .fast      (fast_v_s[gi]),
                .flag      (flag_v_s[gi])
            );

            assign ie_v_s[gi] = ctrl_a[gi][CTRL_IE];
        end
    endgenerate

    // Select the addressed channel's fields (one-hot AND-OR, no priority)
    always_comb begin
        sel_ctrl_s  = {CTRL_W{1'b0}};
        sel_count_s = {WIDTH{1'b0}};
        sel_fast_s  = 1'b0;
        sel_flag_s  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            sel_ctrl_s  = sel_ctrl_s  | (ch_sel_s[i] ? ctrl_a[i]  : {CTRL_W{1'b0}});
            sel_count_s = sel_count_s | (ch_sel_s[i] ? count_a[i] : {WIDTH{1'b0}});
            sel_fast_s  = sel_fast_s  | (ch_sel_s[i] & fast_v_s[i]);
            sel_flag_s  = sel_flag_s  | (ch_sel_s[i] & flag_v_s[i]);
        end
    end

    // Read data mux, zero whenever no read strobe is present
    always_comb begin
        rd_data_s = {WIDTH{1'b0}};
        if (rd_s) begin
            case (reg_s)
                REG_CTRL:   rd_data_s = {{(WIDTH-CTRL_W){1'b0}}, sel_ctrl_s};
                REG_COUNT:  rd_data_s = sel_count_s;
                REG_STATUS: rd_data_s = {{(WIDTH-2){1'b0}}, sel_fast_s, sel_flag_s};
                REG_RSVD:   rd_data_s = {WIDTH{1'b0}};
                default:    rd_data_s = {WIDTH{1'b0}};
            endcase
        end else begin
            rd_data_s = {WIDTH{1'b0}};
        end
    end

    assign D_OUT = rd_data_s;

    // Shared open-drain style interrupt: low while any enabled flag is pending
    assign IRQ_N = ~|(flag_v_s & ie_v_s);

endmodule

// File: tb/tb_mm_timer_array.sv
// -----------------------------------------------------------------------------
// tb_mm_timer_array
// Directed scenarios plus a randomized bus phase, all checked against a
// cycle model of the timer rules held in plain arrays.
// -----------------------------------------------------------------------------
module tb_mm_timer_array;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 4;

    logic             CLK   = 1'b0;
    logic             RES_N = 1'b0;
    logic             CS    = 1'b0;
    logic             WE    = 1'b0;
    logic             RE    = 1'b0;
    logic [AW-1:0]    A     = 4'd0;
    logic [WIDTH-1:0] D_IN  = 8'd0;
    logic [WIDTH-1:0] D_OUT;
    logic             IRQ_N;

    mm_timer_array #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RES_N (RES_N),
        .CS    (CS),
        .WE    (WE),
        .RE    (RE),
        .A     (A),
        .D_IN  (D_IN),
        .D_OUT (D_OUT),
        .IRQ_N (IRQ_N)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model state
    logic [4:0] m_ctrl  [NCH];
    logic [7:0] m_load  [NCH];
    logic [7:0] m_count [NCH];
    int         m_phase [NCH];
    bit         m_fast  [NCH];
    bit         m_flag  [NCH];
    int         div_tab [4] = '{1, 8, 64, 1024};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_ctrl[ch]  = 5'd0;
            m_load[ch]  = 8'd0;
            m_count[ch] = 8'd0;
            m_phase[ch] = 0;
            m_fast[ch]  = 1'b0;
            m_flag[ch]  = 1'b0;
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] addr);
        int ch;
        ch = int'(addr[3:2]);
        case (addr[1:0])
            2'd0:    return {3'd0, m_ctrl[ch]};
            2'd1:    return m_count[ch];
            2'd2:    return {6'd0, m_fast[ch], m_flag[ch]};
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic model_irq_n();
        logic any;
        any = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_flag[ch] && m_ctrl[ch][2]) any = 1'b1;
        end
        return ~any;
    endfunction

    // One clock edge of the timer rules
    function automatic void model_step(input bit cs, input bit we, input bit re,
                                       input logic [3:0] addr, input logic [7:0] data);
        bit run, tick, hit;
        int div;
        for (int ch = 0; ch < NCH; ch++) begin
            run  = m_ctrl[ch][4];
            div  = div_tab[m_ctrl[ch][1:0]];
            tick = run && (m_fast[ch] || (m_phase[ch] == div - 1));
            hit  = cs && (addr[3:2] == 2'(ch));
            if (hit && re && addr[1:0] == 2'd2) m_flag[ch] = 1'b0;
            if (tick) begin
                m_phase[ch] = 0;
                if (m_count[ch] == 8'd0) begin
                    m_flag[ch] = 1'b1;
                    if (m_ctrl[ch][3]) begin
                        m_count[ch] = m_load[ch];
                    end else begin
                        m_count[ch] = 8'hFF;
                        m_fast[ch]  = 1'b1;
                    end
                end else begin
                    m_count[ch] = m_count[ch] - 8'd1;
                end
            end else if (run) begin
                m_phase[ch] = (m_phase[ch] + 1) % 1024;
            end
            if (hit && we && addr[1:0] == 2'd0) m_ctrl[ch] = data[4:0];
            if (hit && we && addr[1:0] == 2'd1) begin
                m_count[ch] = data;
                m_load[ch]  = data;
                m_phase[ch] = 0;
                m_fast[ch]  = 1'b0;
                m_flag[ch]  = 1'b0;
            end
        end
    endfunction

    // One bus cycle; entered and left at the falling edge
    task automatic do_cycle(input bit cs, input bit we, input bit re,
                            input logic [3:0] addr, input logic [7:0] data,
                            output logic [7:0] rdv);
        logic [7:0] exp;
        CS = cs; WE = we; RE = re; A = addr; D_IN = data;
        #1;
        rdv = D_OUT;
        exp = (cs && re) ? model_read(addr) : 8'd0;
        check_eq("dout", 32'(D_OUT), 32'(exp));
        @(posedge CLK);
        model_step(cs, we, re, addr, data);
        cyc++;
        @(negedge CLK);
        check_eq("irq_n", 32'(IRQ_N), 32'(model_irq_n()));
    endtask

    task automatic idle(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, d);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] v);
        logic [7:0] d;
        do_cycle(1'b1, 1'b1, 1'b0, addr, v, d);
    endtask

    task automatic rd(input logic [3:0] addr, output logic [7:0] v);
        do_cycle(1'b1, 1'b0, 1'b1, addr, 8'd0, v);
    endtask

    initial begin
        logic [7:0] v;
        logic [3:0] a;
        int op, start1, start3, s_t, p_t, r_t, u_t;
        bit hit_flag;

        // ---------------- reset state ----------------
        model_reset();
        RES_N = 1'b0;
        #3;
        check_eq("rst_irq0", 32'(IRQ_N), 32'd1);
        CS = 1'b1; RE = 1'b1; A = 4'd1;
        #1;
        check_eq("rst_dout0", 32'(D_OUT), 32'd0);
        CS = 1'b0; RE = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RES_N = 1'b1;
        @(negedge CLK);

        // ---------------- one-shot /8 on ch0 ----------------
        wr(4'd0, 8'h15);
        wr(4'd1, 8'd3);
        idle(8);
        rd(4'd1, v);
        check_eq("os_cnt_after8", 32'(v), 32'd2);
        idle(23);
        rd(4'd1, v);
        check_eq("os_underflow", 32'(v), 32'hFF);
        check_eq("os_irq_low", 32'(IRQ_N), 32'd0);
        rd(4'd2, v);
        check_eq("os_status", 32'(v), 32'h03);
        check_eq("os_irq_clr", 32'(IRQ_N), 32'd1);
        idle(5);
        wr(4'd0, 8'h00);
        rd(4'd2, v);

        // ---------------- auto-reload /1 on ch2 + collisions ----------------
        wr(4'd8, 8'h18);
        wr(4'd9, 8'd4);
        idle(4);
        rd(4'd10, v);                 // this read meets the underflow edge
        check_eq("ar_pre_flag", 32'(v), 32'd0);
        rd(4'd10, v);
        check_eq("col_read_set", 32'(v), 32'd1);
        rd(4'd9, v);
        check_eq("ar_reload", 32'(v), 32'd3);
        rd(4'd10, v);
        check_eq("ar_flag_clr", 32'(v), 32'd0);
        idle(1);
        wr(4'd9, 8'd9);               // write meets the underflow edge
        rd(4'd9, v);
        check_eq("col_wr_cnt", 32'(v), 32'd9);
        rd(4'd10, v);
        check_eq("col_wr_flag", 32'(v), 32'd0);
        idle(40);
        wr(4'd8, 8'h00);
        rd(4'd10, v);

        // ---------------- multi-channel ----------------
        wr(4'd4, 8'h17);
        wr(4'd12, 8'h16);
        wr(4'd5, 8'd1);
        start1 = cyc;
        wr(4'd13, 8'd2);
        start3 = cyc;
        for (int k = 0; k < 400; k++) begin
            idle(1);
            if (IRQ_N == 1'b0) break;
        end
        check_eq("ch3_irq_time", 32'(cyc - start3), 32'd192);
        wr(4'd12, 8'h00);
        rd(4'd14, v);
        check_eq("ch3_status", 32'(v), 32'h03);
        for (int k = 0; k < 2200; k++) begin
            idle(1);
            if (IRQ_N == 1'b0) break;
        end
        check_eq("ch1_irq_time", 32'(cyc - start1), 32'd2048);
        wr(4'd4, 8'h00);
        rd(4'd6, v);

        // ---------------- RUN pause / resume on ch3 ----------------
        wr(4'd12, 8'h12);
        wr(4'd13, 8'd3);
        s_t = cyc;
        idle(100);
        wr(4'd12, 8'h02);
        p_t = cyc;
        idle(50);
        rd(4'd13, v);
        check_eq("hold_cnt", 32'(v), 32'd2);
        idle(10);
        wr(4'd12, 8'h12);
        r_t = cyc;
        u_t = 0;
        hit_flag = 1'b0;
        for (int k = 0; k < 400; k++) begin
            u_t = cyc;
            rd(4'd14, v);
            if (v[0]) begin
                hit_flag = 1'b1;
                break;
            end
        end
        check_eq("resume_flag_seen", 32'(hit_flag), 32'd1);
        check_eq("resume_interval", 32'((p_t - s_t) + (u_t - r_t)), 32'd256);
        wr(4'd12, 8'h00);

        // ---------------- randomized bus traffic ----------------
        for (int k = 0; k < 3000; k++) begin
            op = int'($urandom_range(0, 9));
            a  = 4'($urandom_range(0, 15));
            case (op)
                0, 1, 2, 3: do_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                     a, 8'($urandom), v);
                4: begin
                    v = 8'($urandom_range(0, 31));
                    if (v[1:0] == 2'd3 && $urandom_range(0, 3) != 0) v[1:0] = 2'd1;
                    wr({a[3:2], 2'd0}, v);
                end
                5: wr({a[3:2], 2'd1}, 8'($urandom_range(0, 12)));
                6: wr(a, 8'($urandom));
                7, 8: rd(a, v);
                default: do_cycle(1'b1, 1'b1, 1'b1, a, 8'($urandom), v);
            endcase
        end

        // ---------------- reset mid-count ----------------
        wr(4'd0, 8'h14);
        wr(4'd1, 8'd2);
        idle(5);
        check_eq("pre_rst_irq", 32'(IRQ_N), 32'd0);
        #2;
        RES_N = 1'b0;
        #1;
        check_eq("rst_irq_async", 32'(IRQ_N), 32'd1);
        CS = 1'b1; RE = 1'b1; A = 4'd1;
        #1;
        check_eq("rst_cnt", 32'(D_OUT), 32'd0);
        A = 4'd0;
        #1;
        check_eq("rst_ctrl", 32'(D_OUT), 32'd0);
        A = 4'd2;
        #1;
        check_eq("rst_status", 32'(D_OUT), 32'd0);
        CS = 1'b0; RE = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        model_reset();
        RES_N = 1'b1;
        idle(20);
        rd(4'd1, v);
        check_eq("frozen_zero", 32'(v), 32'd0);
        wr(4'd1, 8'd5);
        idle(20);
        rd(4'd1, v);
        check_eq("frozen_load", 32'(v), 32'd5);
        wr(4'd0, 8'h10);
        idle(3);
        rd(4'd1, v);
        check_eq("run_after_rst", 32'(v), 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
